// File: rtl/project_pwm_peripheral_capture_if.sv
// rtl/project_pwm_peripheral_capture_if.sv - control and result signals of the PWM capture block
interface project_pwm_peripheral_capture_if #(
  parameter int WIDTH = 16
);
  logic             i_enable;
  logic             i_clear;
  logic             i_pwm;
  logic [WIDTH-1:0] o_period;
  logic [WIDTH-1:0] o_high;
  logic             o_valid;
  logic             o_overflow;
  logic             o_busy;

  modport master (
    output i_enable, i_clear, i_pwm,
    input  o_period, o_high, o_valid, o_overflow, o_busy
  );

  modport slave (
    input  i_enable, i_clear, i_pwm,
    output o_period, o_high, o_valid, o_overflow, o_busy
  );
endinterface

// File: rtl/project_pwm_peripheral_capture.sv
// rtl/project_pwm_peripheral_capture.sv - PWM period/high-time capture; optional glitch filter under PWM_CAPTURE_FILTER_EN
module project_pwm_peripheral_capture #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic                               i_clk,
  input  logic                               i_reset,
  project_pwm_peripheral_capture_if.slave    bus
);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_HIGH, S_LOW} state_t;

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (FILTER_LEN < 1) begin : g_bad_filter
    $error("FILTER_LEN must be at least 1");
  end

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_s;
  logic                   w_lvl;
  logic                   r_lvl_d;
  logic                   w_rise;
  logic                   w_fall;
  logic [WIDTH-1:0]       r_cnt;
  logic                   w_sat;
  logic [WIDTH-1:0]       r_high_latch;
  logic [WIDTH-1:0]       r_period;
  logic [WIDTH-1:0]       r_high;
  logic                   r_valid;
  logic                   r_overflow;
  logic                   w_capture;
  logic                   w_latch_high;
  logic                   w_ovf_set;

  // Bring the asynchronous PWM input into the clock domain
  always_ff @(posedge i_clk) begin
    if (i_reset) r_sync <= '0;
    else         r_sync <= {r_sync[SYNC_STAGES-2:0], bus.i_pwm};
  end

  assign w_s = r_sync[SYNC_STAGES-1];

`ifdef PWM_CAPTURE_FILTER_EN
  localparam int FW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN);

  logic [FW-1:0] r_filt_cnt;
  logic          r_filt;

  // Follow the synchronized level only after it has been stable for FILTER_LEN cycles
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_filt_cnt <= '0;
      r_filt     <= 1'b0;
    end else if (w_s == r_filt) begin
      r_filt_cnt <= '0;
    end else if (r_filt_cnt == FW'(FILTER_LEN - 1)) begin
      r_filt     <= w_s;
      r_filt_cnt <= '0;
    end else begin
      r_filt_cnt <= r_filt_cnt + 1'b1;
    end
  end

  assign w_lvl = r_filt;
`else
  assign w_lvl = w_s;
`endif

  // One-cycle delayed copy of the level for edge detection
  always_ff @(posedge i_clk) begin
    if (i_reset) r_lvl_d <= 1'b0;
    else         r_lvl_d <= w_lvl;
  end

  assign w_rise = w_lvl & ~r_lvl_d;
  assign w_fall = ~w_lvl & r_lvl_d;
  assign w_sat  = (r_cnt == CNT_MAX);

  // Cycle counter: restarts at 1 on each rise, saturates instead of wrapping
  always_ff @(posedge i_clk) begin
    if (i_reset || r_state == S_IDLE) r_cnt <= '0;
    else if (w_rise)                  r_cnt <= {{(WIDTH-1){1'b0}}, 1'b1};
    else if (!w_sat)                  r_cnt <= r_cnt + 1'b1;
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next state and capture strobes; disabling wins over everything but reset
  always_comb begin
    w_state_nxt  = r_state;
    w_capture    = 1'b0;
    w_latch_high = 1'b0;
    w_ovf_set    = 1'b0;
    if (!bus.i_enable) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: w_state_nxt = S_ARM;
        S_ARM:  if (w_rise) w_state_nxt = S_HIGH;
        S_HIGH: begin
          if (w_sat) begin
            w_ovf_set   = 1'b1;
            w_state_nxt = S_ARM;
          end else if (w_fall) begin
            w_latch_high = 1'b1;
            w_state_nxt  = S_LOW;
          end
        end
        S_LOW: begin
          if (w_sat) begin
            w_ovf_set   = 1'b1;
            w_state_nxt = S_ARM;
          end else if (w_rise) begin
            w_capture   = 1'b1;
            w_state_nxt = S_HIGH;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Result registers, valid pulse and sticky overflow (a new overflow beats clear)
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_high_latch <= '0;
      r_period     <= '0;
      r_high       <= '0;
      r_valid      <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_valid <= w_capture;
      if (w_latch_high) r_high_latch <= r_cnt;
      if (w_capture) begin
        r_period <= r_cnt;
        r_high   <= r_high_latch;
      end
      if (w_ovf_set)        r_overflow <= 1'b1;
      else if (bus.i_clear) r_overflow <= 1'b0;
    end
  end

  assign bus.o_period   = r_period;
  assign bus.o_high     = r_high;
  assign bus.o_valid    = r_valid;
  assign bus.o_overflow = r_overflow;
  assign bus.o_busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_project_pwm_peripheral_capture.sv
// tb/tb_project_pwm_peripheral_capture.sv - directed self-checking bench for project_pwm_peripheral_capture
module tb_project_pwm_peripheral_capture;

  localparam int WIDTH = 8;
`ifdef PWM_CAPTURE_FILTER_EN
  localparam int LAT = 2 + 3;
`else
  localparam int LAT = 2;
`endif

  logic clk;
  logic rst;

  project_pwm_peripheral_capture_if #(.WIDTH(WIDTH)) bus ();

  project_pwm_peripheral_capture #(
    .WIDTH(WIDTH), .SYNC_STAGES(2), .FILTER_LEN(3)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int nvalid = 0;
  int first_valid_cyc = -1;
  int last_valid_cyc = -1;
  int prev_valid_cyc = -1;
  int rise_cyc = 0;
  int r1, r2, r3;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    if (bus.o_valid === 1'b1) begin
      if (nvalid == 0) first_valid_cyc = cyc;
      nvalid++;
      prev_valid_cyc = last_valid_cyc;
      last_valid_cyc = cyc;
    end
  endtask

  task automatic clear_valid_log();
    nvalid = 0;
    first_valid_cyc = -1;
    last_valid_cyc = -1;
    prev_valid_cyc = -1;
  endtask

  task automatic pwm_period(input int h, input int l);
    rise_cyc = cyc + 1;
    for (int i = 0; i < h; i++) begin bus.i_pwm = 1'b1; tick(); end
    for (int i = 0; i < l; i++) begin bus.i_pwm = 1'b0; tick(); end
  endtask

  task automatic glitch_period();
    for (int i = 0; i < 20; i++) begin bus.i_pwm = 1'b1; tick(); end
    for (int i = 0; i < 2; i++)  begin bus.i_pwm = 1'b0; tick(); end
    for (int i = 0; i < 28; i++) begin bus.i_pwm = 1'b1; tick(); end
    for (int i = 0; i < 50; i++) begin bus.i_pwm = 1'b0; tick(); end
  endtask

  initial begin
    rst = 1'b1;
    bus.i_enable = 1'b0;
    bus.i_clear = 1'b0;
    bus.i_pwm = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("reset_period", 32'(bus.o_period), 0);
    chk("reset_high", 32'(bus.o_high), 0);
    chk("reset_valid", 32'(bus.o_valid), 0);
    chk("reset_overflow", 32'(bus.o_overflow), 0);
    chk("reset_busy", 32'(bus.o_busy), 0);

    // 30/70 stream
    rst = 1'b0;
    bus.i_enable = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("armed_busy", 32'(bus.o_busy), 1);
    clear_valid_log();
    pwm_period(30, 70); r1 = rise_cyc;
    pwm_period(30, 70); r2 = rise_cyc;
    pwm_period(30, 70); r3 = rise_cyc;
    chk("s1_nvalid", nvalid, 2);
    chk("s1_period", 32'(bus.o_period), 100);
    chk("s1_high", 32'(bus.o_high), 30);
    chk("s1_first_valid_cyc", first_valid_cyc, r2 + LAT);
    chk("s1_last_valid_cyc", last_valid_cyc, r3 + LAT);
    chk("s1_valid_spacing", last_valid_cyc - prev_valid_cyc, 100);

    // duty change to 75/25
    clear_valid_log();
    pwm_period(75, 25);
    pwm_period(75, 25);
    chk("s2_nvalid", nvalid, 2);
    chk("s2_period", 32'(bus.o_period), 100);
    chk("s2_high", 32'(bus.o_high), 75);

    // constant high -> saturation after 255 cycles in HIGH
    clear_valid_log();
    rise_cyc = cyc + 1;
    bus.i_pwm = 1'b1;
    while (cyc < rise_cyc + LAT + 254) tick();
    chk("s3_ovf_before_sat", 32'(bus.o_overflow), 0);
    tick();
    chk("s3_ovf_at_sat", 32'(bus.o_overflow), 1);
    chk("s3_busy_arm", 32'(bus.o_busy), 1);
    for (int i = 0; i < 20; i++) tick();
    chk("s3_nvalid", nvalid, 1);
    chk("s3_high", 32'(bus.o_high), 75);
    chk("s3_ovf_sticky", 32'(bus.o_overflow), 1);
    bus.i_clear = 1'b1;
    tick();
    bus.i_clear = 1'b0;
    chk("s3_ovf_cleared", 32'(bus.o_overflow), 0);

    // enable dropped for one cycle mid-period
    for (int i = 0; i < 20; i++) begin bus.i_pwm = 1'b0; tick(); end
    clear_valid_log();
    pwm_period(40, 60);
    pwm_period(40, 60);
    chk("s4_pre_nvalid", nvalid, 1);
    chk("s4_pre_high", 32'(bus.o_high), 40);
    for (int i = 0; i < 40; i++) begin bus.i_pwm = 1'b1; tick(); end
    clear_valid_log();
    for (int i = 0; i < 60; i++) begin
      bus.i_pwm = 1'b0;
      bus.i_enable = (i == 10) ? 1'b0 : 1'b1;
      tick();
    end
    bus.i_enable = 1'b1;
    pwm_period(50, 50); r1 = rise_cyc;
    chk("s4_no_valid", nvalid, 0);
    chk("s4_held_period", 32'(bus.o_period), 100);
    chk("s4_held_high", 32'(bus.o_high), 40);
    pwm_period(20, 80); r2 = rise_cyc;
    chk("s4_nvalid", nvalid, 1);
    chk("s4_first_valid_cyc", first_valid_cyc, r2 + LAT);
    chk("s4_period", 32'(bus.o_period), 100);
    chk("s4_high", 32'(bus.o_high), 50);

    // reset during LOW
    pwm_period(20, 40);
    rst = 1'b1;
    tick();
    chk("s5_period", 32'(bus.o_period), 0);
    chk("s5_high", 32'(bus.o_high), 0);
    chk("s5_valid", 32'(bus.o_valid), 0);
    chk("s5_overflow", 32'(bus.o_overflow), 0);
    chk("s5_busy", 32'(bus.o_busy), 0);
    rst = 1'b0;
    tick();
    chk("s5_busy_arm", 32'(bus.o_busy), 1);
    clear_valid_log();
    pwm_period(30, 70);
    pwm_period(30, 70); r2 = rise_cyc;
    chk("s5_nvalid", nvalid, 1);
    chk("s5_first_valid_cyc", first_valid_cyc, r2 + LAT);
    chk("s5_period_after", 32'(bus.o_period), 100);
    chk("s5_high_after", 32'(bus.o_high), 30);

    // 2-cycle low glitch inside a 50-cycle high pulse
    clear_valid_log();
    glitch_period();
    glitch_period();
`ifdef PWM_CAPTURE_FILTER_EN
    chk("s6_nvalid", nvalid, 2);
    chk("s6_period", 32'(bus.o_period), 100);
    chk("s6_high", 32'(bus.o_high), 50);
`else
    chk("s6_nvalid", nvalid, 4);
    chk("s6_period", 32'(bus.o_period), 22);
    chk("s6_high", 32'(bus.o_high), 20);
`endif
    chk("s6_overflow", 32'(bus.o_overflow), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
